// File: rtl/gpio_bank.sv
// Bank of WIDTH bidirectional GPIO pins on a zero-wait-state Wishbone-style slave bus.
// Provides direction control, atomic set/clear/toggle, synchronized inputs and edge interrupts.
module gpio_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       adr_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [3:0]       sel_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic             irq_o
);

  localparam logic [3:0] AdrOut    = 4'd0;
  localparam logic [3:0] AdrIn     = 4'd1;
  localparam logic [3:0] AdrDir    = 4'd2;
  localparam logic [3:0] AdrSet    = 4'd3;
  localparam logic [3:0] AdrClr    = 4'd4;
  localparam logic [3:0] AdrTgl    = 4'd5;
  localparam logic [3:0] AdrRiseEn = 4'd6;
  localparam logic [3:0] AdrFallEn = 4'd7;
  localparam logic [3:0] AdrStat   = 4'd8;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] stat_clr;
  logic             wr;
  logic [31:0]      rdata;

  assign lane_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wdata     = dat_i[WIDTH-1:0] & wmask;
  assign wr        = stb_i & we_i;

  assign sync_val  = sync_q[SYNC_STAGES-1];
  assign edge_evt  = (sync_val & ~prev_q & rise_en_q) | (~sync_val & prev_q & fall_en_q);

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    stat_clr  = '0;
    if (wr) begin
      case (adr_i)
        AdrOut:    out_d     = (out_q & ~wmask) | wdata;
        AdrDir:    dir_d     = (dir_q & ~wmask) | wdata;
        AdrSet:    out_d     = out_q | wdata;
        AdrClr:    out_d     = out_q & ~wdata;
        AdrTgl:    out_d     = out_q ^ wdata;
        AdrRiseEn: rise_en_d = (rise_en_q & ~wmask) | wdata;
        AdrFallEn: fall_en_d = (fall_en_q & ~wmask) | wdata;
        AdrStat:   stat_clr  = wdata;
        default:   ;
      endcase
    end
    // A new edge event overrides a simultaneous write-1-to-clear.
    stat_d = (stat_q & ~stat_clr) | edge_evt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      prev_q    <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      prev_q    <= sync_val;
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (adr_i)
      AdrOut:    rdata[WIDTH-1:0] = out_q;
      AdrIn:     rdata[WIDTH-1:0] = sync_val;
      AdrDir:    rdata[WIDTH-1:0] = dir_q;
      AdrRiseEn: rdata[WIDTH-1:0] = rise_en_q;
      AdrFallEn: rdata[WIDTH-1:0] = fall_en_q;
      AdrStat:   rdata[WIDTH-1:0] = stat_q;
      default:   rdata = '0;
    endcase
  end

  assign dat_o     = rdata;
  assign ack_o     = stb_i;
  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = |stat_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: a 32-pin and an 8-pin instance share one bus and pad set,
// checked against a register-level model where pad values appear SYNC_STAGES cycles late.
module tb_gpio_bank;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  adr;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic [31:0] pad;

  logic [31:0] dat_o32, gpio_o32, oe32;
  logic        ack32, irq32;
  logic [31:0] dat_o8;
  logic [7:0]  gpio_o8, oe8;
  logic        ack8, irq8;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_out, m_dir, m_re, m_fe, m_stat;
  logic [31:0] hist [S+1];  // hist[0] = pad sampled at the latest edge

  always #5 clk = ~clk;

  gpio_bank #(.WIDTH(32), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_ni(rst_n), .adr_i(adr), .stb_i(stb), .we_i(we), .sel_i(sel),
    .dat_i(dat), .dat_o(dat_o32), .ack_o(ack32), .gpio_o(gpio_o32), .gpio_oe_o(oe32),
    .gpio_i(pad), .irq_o(irq32)
  );

  gpio_bank #(.WIDTH(8), .SYNC_STAGES(S)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .adr_i(adr), .stb_i(stb), .we_i(we), .sel_i(sel),
    .dat_i(dat), .dat_o(dat_o8), .ack_o(ack8), .gpio_o(gpio_o8), .gpio_oe_o(oe8),
    .gpio_i(pad[7:0]), .irq_o(irq8)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_bits(input logic [3:0] sl);
    return {{8{sl[3]}}, {8{sl[2]}}, {8{sl[1]}}, {8{sl[0]}}};
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return m_out;
      4'd1:    return hist[S-1];
      4'd2:    return m_dir;
      4'd6:    return m_re;
      4'd7:    return m_fe;
      4'd8:    return m_stat;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_re = 0; m_fe = 0; m_stat = 0;
    for (int i = 0; i <= S; i++) hist[i] = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_value({tag, ".gpio_o"}, gpio_o32, m_out);
    check_value({tag, ".oe"}, oe32, m_dir);
    check_value({tag, ".irq"}, {31'b0, irq32}, {31'b0, |m_stat});
    check_value({tag, ".ack"}, {31'b0, ack32}, {31'b0, stb});
    check_value({tag, ".gpio_o8"}, {24'b0, gpio_o8}, m_out & 32'hFF);
    check_value({tag, ".oe8"}, {24'b0, oe8}, m_dir & 32'hFF);
    check_value({tag, ".irq8"}, {31'b0, irq8}, {31'b0, |m_stat[7:0]});
  endtask

  // Compares both instances' read data against the model at address a.
  task automatic check_read(input string tag, input logic [3:0] a);
    adr = a;
    #1;
    check_value({tag, ".rd32"}, dat_o32, model_read(a));
    check_value({tag, ".rd8"}, dat_o8, model_read(a) & 32'hFF);
  endtask

  // Compares the 32-pin instance's read data against a fixed expected value.
  task automatic check_lit(input string tag, input logic [3:0] a, input logic [31:0] exp);
    adr = a;
    #1;
    check_value(tag, dat_o32, exp);
  endtask

  // One bus cycle; the model advances by the same clock edge.
  task automatic cycle(input logic w, input logic [3:0] a, input logic [3:0] sl,
                       input logic [31:0] d);
    logic [31:0] m, sync_b, prev_b, ev, clr;
    stb = 1'b1; we = w; adr = a; sel = sl; dat = d;
    m = lane_bits(sl) & d;
    sync_b = hist[S-1];
    prev_b = hist[S];
    ev = (sync_b & ~prev_b & m_re) | (~sync_b & prev_b & m_fe);
    clr = 0;
    if (w) begin
      case (a)
        4'd0: m_out = (m_out & ~lane_bits(sl)) | m;
        4'd2: m_dir = (m_dir & ~lane_bits(sl)) | m;
        4'd3: m_out = m_out | m;
        4'd4: m_out = m_out & ~m;
        4'd5: m_out = m_out ^ m;
        4'd6: m_re  = (m_re & ~lane_bits(sl)) | m;
        4'd7: m_fe  = (m_fe & ~lane_bits(sl)) | m;
        4'd8: clr   = m;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | ev;
    for (int i = S; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pad;
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; stb = 0; we = 0; adr = 0; sel = 0; dat = 0; pad = 0;
    model_reset();
    #12;
    check_outputs("reset");
    for (int a = 0; a < 16; a++) begin
      adr = a[3:0];
      #1;
      check_value("reset_rd", dat_o32, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Byte-lane writes and atomic set/clear/toggle
    cycle(1'b1, 4'd0, 4'b0101, 32'h12345678);
    check_lit("out_sel", 4'd0, 32'h00340078);
    cycle(1'b1, 4'd3, 4'hF, 32'hFF000000);
    check_lit("out_set", 4'd0, 32'hFF340078);
    check_lit("set_rd0", 4'd3, 32'h0);
    cycle(1'b1, 4'd4, 4'hF, 32'h00000070);
    check_lit("out_clr", 4'd0, 32'hFF340008);
    check_lit("clr_rd0", 4'd4, 32'h0);
    cycle(1'b1, 4'd5, 4'hF, 32'h0000000F);
    check_lit("out_tgl", 4'd0, 32'hFF340007);
    check_lit("tgl_rd0", 4'd5, 32'h0);
    check_outputs("after_tgl");

    // Direction and input latency
    cycle(1'b1, 4'd2, 4'hF, 32'h0000FFFF);
    check_value("oe_lit", oe32, 32'h0000FFFF);
    pad = 32'hA5A50000;
    cycle(1'b0, 4'd1, 4'h0, 32'h0);
    check_lit("in_early", 4'd1, 32'h0);
    cycle(1'b0, 4'd1, 4'h0, 32'h0);
    check_lit("in_lat", 4'd1, 32'hA5A50000);
    check_read("in_model", 4'd1);

    // Edge interrupts and write-1-to-clear
    pad = 32'hA5A50002;
    idle(S + 1);
    cycle(1'b1, 4'd6, 4'hF, 32'h1);
    cycle(1'b1, 4'd7, 4'hF, 32'h2);
    pad[0] = 1'b1;
    idle(S);
    check_value("irq_early", {31'b0, irq32}, 32'h0);
    idle(1);
    check_lit("stat_rise", 4'd8, 32'h1);
    check_value("irq_rise", {31'b0, irq32}, 32'h1);
    pad[1] = 1'b0;
    idle(S + 1);
    check_lit("stat_fall", 4'd8, 32'h3);
    pad[0] = 1'b0;
    idle(S + 1);
    check_lit("stat_nofall0", 4'd8, 32'h3);
    cycle(1'b1, 4'd8, 4'hF, 32'h1);
    check_lit("stat_w1c0", 4'd8, 32'h2);
    check_value("irq_still", {31'b0, irq32}, 32'h1);
    cycle(1'b1, 4'd8, 4'hF, 32'h2);
    check_value("irq_clear", {31'b0, irq32}, 32'h0);
    check_outputs("after_w1c");

    // Set wins over a simultaneous clear
    pad[0] = 1'b1;
    idle(S);
    cycle(1'b1, 4'd8, 4'hF, 32'h1);
    check_lit("set_wins", 4'd8, 32'h1);
    check_read("set_wins_m", 4'd8);
    cycle(1'b1, 4'd8, 4'hF, 32'h1);
    check_lit("stat_zero", 4'd8, 32'h0);

    // Narrow instance and reserved address
    cycle(1'b1, 4'd0, 4'hF, 32'hFFFFFFFF);
    adr = 4'd0;
    #1;
    check_value("w8_out", dat_o8, 32'h000000FF);
    cycle(1'b1, 4'd12, 4'hF, 32'hDEADBEEF);
    check_lit("rsvd32", 4'd12, 32'h0);
    check_value("rsvd8", dat_o8, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      check_read("rnd", a);
      if (n % 8 == 0) check_outputs("rnd");
      case ($urandom_range(0, 3))
        0: pad = $urandom;
        1: pad[$urandom_range(0, 31)] = ~pad[$urandom_range(0, 31)];
        default: ;
      endcase
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom), $urandom);
    end

    // Asynchronous reset between clock edges
    cycle(1'b1, 4'd2, 4'hF, 32'hFFFFFFFF);
    cycle(1'b1, 4'd0, 4'hF, 32'h5A5A5A5A);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    check_lit("async_rd", 4'd0, 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(S + 2);
    check_read("post_rst_in", 4'd1);
    check_outputs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
